top_duv: RTL and testbench
==========================

# top_duv

Multicycle RV32I-subset processor core, the design under verification in the multicycle test environment. It executes one instruction over 3–5 clock cycles through a single shared ALU. It talks to one unified instruction/data memory through a simple word-addressed bus. A reference model drives the same bus signals in parallel for comparison.

## Interface
- `TAMANYO`, default 32: datapath, address and register width.
- `CLK` in 1: single clock, rising edge.
- `RSTa` in 1: asynchronous, active-low reset.
- `address` out 32: memory byte address. Equals PC in FETCH and ALUOut in memory states.
- `read_address` in 32: memory read data, combinational with respect to `address`.
- `write_data` out 32: store data (register rs2 value).
- `MemWrite` out 1: store strobe. Memory writes `write_data` at `address` on the rising edge.
- `MemRead` out 1: read strobe. Core samples `read_address` on the rising edge.

## Operation
- Supported instructions:
  - R-type: add, sub, and, or, xor, slt, sltu, sll, srl, sra.
  - I-type: addi, andi, ori, xori, slti, sltiu, slli, srli, srai.
  - Memory: lw, sw.
  - Branches: beq, bne.
  - Other: jal, lui.
- Unknown opcodes or funct combinations execute as a NOP: FETCH→DECODE→FETCH.
- FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, LUI.
- FETCH
  - `address`=PC, `MemRead`=1.
  - On the edge: IR←`read_address`, OldPC←PC, PC←PC+4.
- DECODE
  - Read rs1 and rs2 into A and B.
  - ALUOut←OldPC+immB (branch target), computed speculatively.
  - Next state is chosen by opcode.
- lw: MEMADR (ALUOut←A+immI) → MEMREAD (`address`=ALUOut, `MemRead`=1, MDR←data) → MEMWB (rd←MDR).
- sw: MEMADR (ALUOut←A+immS) → MEMWRITE (`address`=ALUOut, `write_data`=B, `MemWrite`=1).
- Arithmetic: EXEC_R or EXEC_I (ALUOut←A op B/imm) → ALUWB (rd←ALUOut).
- BRANCH: if the condition holds, PC←ALUOut; otherwise PC stays at OldPC+4.
- JAL: rd←OldPC+4, PC←OldPC+immJ.
- LUI: rd←{imm[31:12],12'b0}.
- Arithmetic and width rules:
  - Arithmetic is 32-bit, wrap-around, with no overflow trap.
  - Shift amount is the low 5 bits of the operand.
  - slt compares signed; sltu compares unsigned.
  - Immediates are sign-extended.
- Writes to x0 are discarded; x0 always reads 0.
- Addresses are used unaligned-unchecked; the low 2 bits are passed through.

## Timing
- Cycle counts: branch, jal and lui take 3 cycles; R/I-type and sw take 4; lw takes 5.
- `MemRead` and `MemWrite` are never high in the same cycle.
- `MemRead`/`MemWrite` are high for exactly one cycle per access.
- All bus outputs are decoded combinationally from the state and registers.
- While `RSTa`=0:
  - State=FETCH, PC=0, IR/A/B/ALUOut/MDR/OldPC=0, all 32 registers=0.
  - Outputs: `address`=0, `MemRead`=1, `MemWrite`=0, `write_data`=0.
- First fetch completes on the first rising edge after `RSTa` rises.
- Reset asserted mid-instruction aborts it immediately; no partial write occurs after reset.

## Configuration
- `TOP_DUV_SHIFT_EN`
  - Defined: sll/srl/sra/slli/srli/srai are implemented as above.
  - Undefined: these encodings decode as NOP (no register write, PC+4), and the ALU has no shifter.

## Structure
- Package `top_duv_pkg` holds:
  - Opcode constants (OP_R 0110011, OP_I 0010011, OP_LW 0000011, OP_SW 0100011, OP_BR 1100011, OP_JAL 1101111, OP_LUI 0110111).
  - The FSM state enum.
  - The ALU-operation enum.
- One sub-module, `top_duv_alu`: combinational; inputs a, b and op; outputs result and zero.
- Register file, FSM and datapath registers live in `top_duv`.

## Test plan
- Reset with PC=0 → `address`=0 and `MemRead`=1 during reset; first instruction fetched at 0x0, second fetch at 0x4 after 3–5 cycles.
- Memory 0x0: addi x1,x0,5 (0x00500093); 0x4: sw x1,0x40(x0) (0x04102023) → on cycle 8, `MemWrite`=1, `address`=0x40, `write_data`=5.
- Memory 0x40=0xDEADBEEF; lw x2,0x40(x0) then sw x2,0x44(x0) → store of 0xDEADBEEF to 0x44; the lw takes 5 cycles.
- x1=5, x2=5; beq x1,x2,+8 → next fetch `address`=PC+8; with bne the next fetch is PC+4.
- addi x0,x0,7 then sw x0,0x48(x0) → `write_data`=0. Also: jal x3,+16 at 0x10 → next fetch 0x20, and x3 later stored as 0x14.
- With `TOP_DUV_SHIFT_EN`, x1=0x80000000, srai x4,x1,4 → x4=0xF8000000. Without it, x4 stays unchanged.

Source files
------------

// File: rtl/top_duv_pkg.sv
// ---------------------------------------------------------------------------
// top_duv_pkg
// Shared definitions for the multicycle RV32I-subset core:
//   - opcode constants for the supported instruction classes
//   - FSM state enumeration
//   - ALU operation enumeration
//   - alu_decode(): maps funct3/funct7 to an ALU operation plus a valid flag
// Build option: TOP_DUV_SHIFT_EN enables the shift instructions
// (sll/srl/sra/slli/srli/srai); without it those encodings decode as invalid.
// ---------------------------------------------------------------------------
package top_duv_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXEC_R,
        EXEC_I,
        ALUWB,
        BRANCH,
        JAL,
        LUI
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA
    } alu_op_e;

    typedef struct packed {
        logic    valid;
        alu_op_e op;
    } alu_dec_t;

    // is_reg selects R-type rules: funct7 must be 0 except for sub/sra.
    // For I-type, funct7 is part of the immediate and is only inspected
    // for the shift encodings.
    function automatic alu_dec_t alu_decode(input logic [2:0] funct3,
                                            input logic [6:0] funct7,
                                            input logic       is_reg);
        alu_dec_t d;
        logic     f7_zero;
        logic     f7_alt;
        f7_zero = (funct7 == 7'b0000000);
        f7_alt  = (funct7 == 7'b0100000);
        d.valid = 1'b0;
        d.op    = ALU_ADD;
        case (funct3)
            3'b000: begin
                if (!is_reg || f7_zero) begin
                    d.valid = 1'b1;
                    d.op    = ALU_ADD;
                end else if (f7_alt) begin
                    d.valid = 1'b1;
                    d.op    = ALU_SUB;
                end
            end
            3'b010: begin d.valid = !is_reg || f7_zero; d.op = ALU_SLT;  end
            3'b011: begin d.valid = !is_reg || f7_zero; d.op = ALU_SLTU; end
            3'b100: begin d.valid = !is_reg || f7_zero; d.op = ALU_XOR;  end
            3'b110: begin d.valid = !is_reg || f7_zero; d.op = ALU_OR;   end
            3'b111: begin d.valid = !is_reg || f7_zero; d.op = ALU_AND;  end
`ifdef TOP_DUV_SHIFT_EN
            3'b001: begin d.valid = f7_zero; d.op = ALU_SLL; end
            3'b101: begin
                d.valid = f7_zero || f7_alt;
                d.op    = f7_alt ? ALU_SRA : ALU_SRL;
            end
`endif
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/top_duv_alu.sv
// ---------------------------------------------------------------------------
// top_duv_alu
// Combinational ALU shared by every datapath step of the core.
// Ports:
//   a, b    in  W  operands
//   op      in     operation (alu_op_e)
//   result  out W  operation result (32-bit style wrap-around)
//   zero    out 1  result == 0
// Build option: TOP_DUV_SHIFT_EN adds the shifter; without it shift
// operations are never requested and yield 0.
// ---------------------------------------------------------------------------
module top_duv_alu
    import top_duv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_op_e      op,
    output logic [W-1:0] result,
    output logic         zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result[0] = ($signed(a) < $signed(b));
            ALU_SLTU: result[0] = (a < b);
`ifdef TOP_DUV_SHIFT_EN
            ALU_SLL:  result = a << b[4:0];
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
`endif
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/top_duv.sv
// ---------------------------------------------------------------------------
// top_duv
// Multicycle RV32I-subset core (add/sub/logic/slt/shift R+I, lw, sw, beq,
// bne, jal, lui). One instruction takes 3..5 cycles through one shared ALU.
// Ports:
//   CLK           in   clock, rising edge
//   RSTa          in   asynchronous active-low reset
//   address       out  memory byte address (PC in FETCH, ALUOut in MEMREAD/MEMWRITE)
//   read_address  in   memory read data (combinational from address)
//   write_data    out  store data (B register = rs2 value)
//   MemWrite      out  store strobe, memory writes on the rising edge
//   MemRead       out  read strobe, core samples read_address on the rising edge
// Build option: TOP_DUV_SHIFT_EN enables shift instructions; otherwise they
// decode as NOP.
// ---------------------------------------------------------------------------
module top_duv
    import top_duv_pkg::*;
#(
    parameter int TAMANYO = 32
) (
    input  logic               CLK,
    input  logic               RSTa,
    output logic [TAMANYO-1:0] address,
    input  logic [TAMANYO-1:0] read_address,
    output logic [TAMANYO-1:0] write_data,
    output logic               MemWrite,
    output logic               MemRead
);

    state_e             state_q, state_d;
    logic [TAMANYO-1:0] pc_q, old_pc_q, a_q, b_q, alu_out_q, mdr_q;
    logic [31:0]        ir_q;
    logic [TAMANYO-1:0] rf_q [32];

    // Instruction fields
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    // Immediates, built at 32 bits then sign-extended to the datapath width
    logic [31:0]        imm_i32, imm_s32, imm_b32, imm_j32, imm_u32;
    logic [TAMANYO-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    assign imm_i32 = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign imm_u32 = {ir_q[31:12], 12'b0};
    assign imm_i   = TAMANYO'($signed(imm_i32));
    assign imm_s   = TAMANYO'($signed(imm_s32));
    assign imm_b   = TAMANYO'($signed(imm_b32));
    assign imm_j   = TAMANYO'($signed(imm_j32));
    assign imm_u   = TAMANYO'($signed(imm_u32));

    alu_dec_t alu_dec;
    assign alu_dec = alu_decode(funct3, funct7, opcode == OP_R);

    // Register-file read ports; x0 is hard-wired to zero
    logic [TAMANYO-1:0] rs1_val, rs2_val;
    assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

    // Shared ALU operand selection
    logic [TAMANYO-1:0] alu_a, alu_b, alu_result;
    alu_op_e            alu_op;
    logic               alu_zero;

    always_comb begin
        alu_a  = pc_q;
        alu_b  = TAMANYO'(32'd4);
        alu_op = ALU_ADD;
        case (state_q)
            DECODE: begin           // speculative branch target
                alu_a = old_pc_q;
                alu_b = imm_b;
            end
            MEMADR: begin
                alu_a = a_q;
                alu_b = (opcode == OP_SW) ? imm_s : imm_i;
            end
            EXEC_R: begin
                alu_a  = a_q;
                alu_b  = b_q;
                alu_op = alu_dec.op;
            end
            EXEC_I: begin
                alu_a  = a_q;
                alu_b  = imm_i;
                alu_op = alu_dec.op;
            end
            BRANCH: begin           // equality via subtract-and-test-zero
                alu_a  = a_q;
                alu_b  = b_q;
                alu_op = ALU_SUB;
            end
            JAL: begin
                alu_a = old_pc_q;
                alu_b = imm_j;
            end
            default: ;
        endcase
    end

    top_duv_alu #(.W(TAMANYO)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Next-state logic; anything not recognised falls back to FETCH (NOP)
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_R:   state_d = alu_dec.valid ? EXEC_R : FETCH;
                    OP_I:   state_d = alu_dec.valid ? EXEC_I : FETCH;
                    OP_LW:  state_d = (funct3 == 3'b010) ? MEMADR : FETCH;
                    OP_SW:  state_d = (funct3 == 3'b010) ? MEMADR : FETCH;
                    OP_BR:  state_d = (funct3[2:1] == 2'b00) ? BRANCH : FETCH;
                    OP_JAL: state_d = JAL;
                    OP_LUI: state_d = LUI;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD: state_d = MEMWB;
            EXEC_R:  state_d = ALUWB;
            EXEC_I:  state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    // Register-file write port
    logic               rf_we;
    logic [TAMANYO-1:0] rf_wdata;
    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = alu_out_q;
        case (state_q)
            MEMWB: begin rf_we = 1'b1; rf_wdata = mdr_q;     end
            ALUWB: begin rf_we = 1'b1; rf_wdata = alu_out_q; end
            JAL:   begin rf_we = 1'b1; rf_wdata = pc_q;      end  // pc_q already OldPC+4
            LUI:   begin rf_we = 1'b1; rf_wdata = imm_u;     end
            default: ;
        endcase
        if (rd == 5'd0) rf_we = 1'b0;
    end

    logic branch_taken;
    assign branch_taken = funct3[0] ? !alu_zero : alu_zero;

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state_q   <= FETCH;
            pc_q      <= '0;
            old_pc_q  <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                FETCH: begin
                    ir_q     <= read_address[31:0];
                    old_pc_q <= pc_q;
                    pc_q     <= alu_result;
                end
                DECODE: begin
                    a_q       <= rs1_val;
                    b_q       <= rs2_val;
                    alu_out_q <= alu_result;
                end
                MEMADR, EXEC_R, EXEC_I: alu_out_q <= alu_result;
                MEMREAD: mdr_q <= read_address;
                BRANCH:  if (branch_taken) pc_q <= alu_out_q;
                JAL:     pc_q <= alu_result;
                default: ;
            endcase
            if (rf_we) rf_q[rd] <= rf_wdata;
        end
    end

    // Bus outputs decoded from state and registers
    assign MemRead    = (state_q == FETCH) || (state_q == MEMREAD);
    assign MemWrite   = (state_q == MEMWRITE);
    assign address    = ((state_q == MEMREAD) || (state_q == MEMWRITE)) ? alu_out_q : pc_q;
    assign write_data = b_q;

endmodule

// File: tb/tb_top_duv.sv
// Testbench for top_duv: unified memory model, ISA-level reference model,
// per-cycle bus trace comparison plus directed scenarios.
module tb_top_duv;

    localparam logic [31:0] HALT  = 32'h0000006F;   // jal x0,0
    localparam logic [31:0] NOP   = 32'h00000013;   // addi x0,x0,0
    localparam logic [6:0]  O_I   = 7'b0010011;
    localparam logic [6:0]  O_LW  = 7'b0000011;
`ifdef TOP_DUV_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic        CLK;
    logic        RSTa;
    logic [31:0] address, read_address, write_data;
    logic        MemWrite, MemRead;

    logic [31:0] mem       [256];
    logic [31:0] model_mem [256];
    logic [31:0] prog_q    [$];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
        int          kind;     // 0 none, 1 store, 2 load
        logic [31:0] maddr;
        logic [31:0] mdata;
    } ev_t;
    ev_t ev_q [$];

    top_duv #(.TAMANYO(32)) dut (
        .CLK          (CLK),
        .RSTa         (RSTa),
        .address      (address),
        .read_address (read_address),
        .write_data   (write_data),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign read_address = mem[address[9:2]];
    always @(posedge CLK) if (MemWrite === 1'b1) mem[address[9:2]] = write_data;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    // ---------------- reference model ----------------
    // Bit 32 of the return value flags a legal arithmetic encoding.
    function automatic logic [32:0] arith(input logic [2:0] f3, input logic [6:0] f7,
                                          input bit is_r, input logic [31:0] a,
                                          input logic [31:0] b);
        bit plain;
        bit alt;
        bit std;
        plain = (f7 == 7'h00);
        alt   = (f7 == 7'h20);
        std   = !is_r || plain;
        case (f3)
            3'd0: if (std) return {1'b1, a + b};
                  else if (alt) return {1'b1, a - b};
            3'd1: if (SHIFT_EN && plain) return {1'b1, a << b[4:0]};
            3'd2: if (std) return {1'b1, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
            3'd3: if (std) return {1'b1, (a < b) ? 32'd1 : 32'd0};
            3'd4: if (std) return {1'b1, a ^ b};
            3'd5: if (SHIFT_EN && plain) return {1'b1, a >> b[4:0]};
                  else if (SHIFT_EN && alt) return {1'b1, 32'($signed(a) >>> b[4:0])};
            3'd6: if (std) return {1'b1, a | b};
            default: if (std) return {1'b1, a & b};
        endcase
        return 33'd0;
    endfunction

    task automatic model_run();
        logic [31:0] xr [32];
        logic [31:0] pc, ir, a, b, res, npc, iimm, simm, bimm, jimm;
        logic [32:0] r;
        logic [6:0]  op, f7;
        logic [4:0]  rd;
        logic [2:0]  f3;
        bit          wr;
        ev_t         e;
        for (int i = 0; i < 256; i++) model_mem[i] = mem[i];
        for (int i = 0; i < 32; i++) xr[i] = 32'd0;
        pc = 32'd0;
        ev_q.delete();
        for (int n = 0; n < 2000; n++) begin
            ir   = model_mem[pc[9:2]];
            op   = ir[6:0];
            rd   = ir[11:7];
            f3   = ir[14:12];
            f7   = ir[31:25];
            a    = xr[ir[19:15]];
            b    = xr[ir[24:20]];
            iimm = {{20{ir[31]}}, ir[31:20]};
            simm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            bimm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            jimm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            e.pc = pc; e.cyc = 2; e.kind = 0; e.maddr = 32'd0; e.mdata = 32'd0;
            wr = 1'b0; res = 32'd0; npc = pc + 32'd4;
            case (op)
                7'b0110011, 7'b0010011: begin
                    r = arith(f3, f7, op == 7'b0110011, a, (op == 7'b0110011) ? b : iimm);
                    if (r[32]) begin wr = 1'b1; res = r[31:0]; e.cyc = 4; end
                end
                7'b0000011: if (f3 == 3'd2) begin
                    e.cyc = 5; e.kind = 2; e.maddr = a + iimm;
                    res = model_mem[e.maddr[9:2]]; wr = 1'b1;
                end
                7'b0100011: if (f3 == 3'd2) begin
                    e.cyc = 4; e.kind = 1; e.maddr = a + simm; e.mdata = b;
                    model_mem[e.maddr[9:2]] = b;
                end
                7'b1100011: if (f3 == 3'd0 || f3 == 3'd1) begin
                    e.cyc = 3;
                    if ((f3 == 3'd0) == (a == b)) npc = pc + bimm;
                end
                7'b1101111: begin e.cyc = 3; wr = 1'b1; res = pc + 32'd4; npc = pc + jimm; end
                7'b0110111: begin e.cyc = 3; wr = 1'b1; res = {ir[31:12], 12'b0}; end
                default: ;
            endcase
            if (wr && rd != 5'd0) xr[rd] = res;
            ev_q.push_back(e);
            if (ir == HALT) break;
            pc = npc;
        end
    endtask

    // ---------------- program handling ----------------
    // Called at a falling edge: holds reset while memory is (re)loaded.
    task automatic start_prog();
        @(negedge CLK);
        RSTa = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = (i < prog_q.size()) ? prog_q[i] : HALT;
        for (int i = 128; i < 256; i++) mem[i] = $urandom;
    endtask

    // Releases reset and compares the bus cycle by cycle with the model trace.
    task automatic run_prog(input string name);
        model_run();
        @(negedge CLK);
        RSTa = 1'b1;
        foreach (ev_q[k]) begin
            for (int c = 0; c < ev_q[k].cyc; c++) begin
                checks++;
                if (c == 0) begin
                    if (address !== ev_q[k].pc || MemRead !== 1'b1 || MemWrite !== 1'b0) begin
                        errors++;
                        $display("FAIL %s fetch#%0d: address=%h MemRead=%b MemWrite=%b, required address=%h MemRead=1 MemWrite=0",
                                 name, k, address, MemRead, MemWrite, ev_q[k].pc);
                    end
                end else if (c == 3 && ev_q[k].kind == 1) begin
                    $display("%s store pc=%h addr=%h data=%h", name, ev_q[k].pc, address, write_data);
                    if (MemWrite !== 1'b1 || MemRead !== 1'b0 || address !== ev_q[k].maddr ||
                        write_data !== ev_q[k].mdata) begin
                        errors++;
                        $display("FAIL %s store pc=%h: MemWrite=%b MemRead=%b address=%h data=%h, required 1 0 %h %h",
                                 name, ev_q[k].pc, MemWrite, MemRead, address, write_data,
                                 ev_q[k].maddr, ev_q[k].mdata);
                    end
                end else if (c == 3 && ev_q[k].kind == 2) begin
                    $display("%s load  pc=%h addr=%h", name, ev_q[k].pc, address);
                    if (MemRead !== 1'b1 || MemWrite !== 1'b0 || address !== ev_q[k].maddr) begin
                        errors++;
                        $display("FAIL %s load pc=%h: MemRead=%b MemWrite=%b address=%h, required 1 0 %h",
                                 name, ev_q[k].pc, MemRead, MemWrite, address, ev_q[k].maddr);
                    end
                end else begin
                    if (MemRead !== 1'b0 || MemWrite !== 1'b0) begin
                        errors++;
                        $display("FAIL %s idle pc=%h cycle %0d: MemRead=%b MemWrite=%b, required 0 0",
                                 name, ev_q[k].pc, c, MemRead, MemWrite);
                    end
                end
                @(negedge CLK);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        prog_q.delete();
        prog_q.push_back(enc_i(12'd5, 5'd0, 3'd0, 5'd1, O_I));
        prog_q.push_back(enc_s(12'h040, 5'd1, 5'd0));
        start_prog();
        mem[16] = 32'd0;
        @(negedge CLK);
        checks++;
        if (address !== 32'd0 || MemRead !== 1'b1 || MemWrite !== 1'b0 || write_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: address=%h MemRead=%b MemWrite=%b write_data=%h, required 0 1 0 0",
                     address, MemRead, MemWrite, write_data);
        end
        RSTa = 1'b1;
        repeat (7) @(negedge CLK);
        checks++;
        if (MemWrite !== 1'b1 || address !== 32'h40) begin
            errors++;
            $display("FAIL store_cycle8: MemWrite=%b address=%h, required 1 00000040", MemWrite, address);
        end
        RSTa = 1'b0;        // abort the store mid-cycle
        #1;
        checks++;
        if (MemWrite !== 1'b0 || MemRead !== 1'b1 || address !== 32'd0) begin
            errors++;
            $display("FAIL reset_async: MemWrite=%b MemRead=%b address=%h, required 0 1 0",
                     MemWrite, MemRead, address);
        end
        @(negedge CLK);
        checks++;
        if (mem[16] !== 32'd0) begin
            errors++;
            $display("FAIL reset_no_write: mem[0x40]=%h, required 00000000", mem[16]);
        end
        // x1 was written before the reset; it must read back as zero now
        prog_q.delete();
        prog_q.push_back(enc_s(12'h040, 5'd1, 5'd0));
        start_prog();
        mem[16] = 32'hFFFFFFFF;
        run_prog("reset_regs");
        checks++;
        if (mem[16] !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs_cleared: mem[0x40]=%h, required 00000000", mem[16]);
        end
    endtask

    task automatic test_addi_sw();
        prog_q.delete();
        prog_q.push_back(32'h00500093);
        prog_q.push_back(32'h04102023);
        start_prog();
        mem[16] = 32'd0;
        run_prog("addi_sw");
        checks++;
        if (mem[16] !== 32'd5) begin
            errors++;
            $display("FAIL addi_sw: mem[0x40]=%h, required 00000005", mem[16]);
        end
    endtask

    task automatic test_load_store();
        prog_q.delete();
        prog_q.push_back(enc_i(12'h040, 5'd0, 3'd2, 5'd2, O_LW));
        prog_q.push_back(enc_s(12'h044, 5'd2, 5'd0));
        start_prog();
        mem[16] = 32'hDEADBEEF;
        mem[17] = 32'd0;
        run_prog("lw_sw");
        checks++;
        if (mem[17] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_sw: mem[0x44]=%h, required deadbeef", mem[17]);
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp_v;
        for (int bne = 0; bne < 2; bne++) begin
            prog_q.delete();
            prog_q.push_back(enc_i(12'd5, 5'd0, 3'd0, 5'd1, O_I));
            prog_q.push_back(enc_i(12'd5, 5'd0, 3'd0, 5'd2, O_I));
            prog_q.push_back(enc_i(12'h011, 5'd0, 3'd0, 5'd3, O_I));
            prog_q.push_back(enc_b(13'd8, 5'd2, 5'd1, 3'(bne)));
            prog_q.push_back(enc_i(12'h022, 5'd0, 3'd0, 5'd3, O_I));
            prog_q.push_back(enc_s(12'h048, 5'd3, 5'd0));
            start_prog();
            mem[18] = 32'hFFFFFFFF;
            run_prog(bne != 0 ? "bne" : "beq");
            exp_v = (bne != 0) ? 32'h22 : 32'h11;
            checks++;
            if (mem[18] !== exp_v) begin
                errors++;
                $display("FAIL branch bne=%0d: mem[0x48]=%h, required %h", bne, mem[18], exp_v);
            end
        end
    endtask

    task automatic test_x0_jal();
        prog_q.delete();
        prog_q.push_back(enc_i(12'd7, 5'd0, 3'd0, 5'd0, O_I));
        prog_q.push_back(enc_s(12'h048, 5'd0, 5'd0));
        prog_q.push_back(NOP);
        prog_q.push_back(NOP);
        prog_q.push_back(enc_j(21'd16, 5'd3));                 // at 0x10
        for (int i = 0; i < 3; i++) prog_q.push_back(enc_i(12'd1, 5'd0, 3'd0, 5'd3, O_I));
        prog_q.push_back(enc_s(12'h04C, 5'd3, 5'd0));          // at 0x20
        start_prog();
        mem[18] = 32'hFFFFFFFF;
        mem[19] = 32'd0;
        run_prog("x0_jal");
        checks++;
        if (mem[18] !== 32'd0) begin
            errors++;
            $display("FAIL x0_write: mem[0x48]=%h, required 00000000", mem[18]);
        end
        checks++;
        if (mem[19] !== 32'h14) begin
            errors++;
            $display("FAIL jal_link: mem[0x4c]=%h, required 00000014", mem[19]);
        end
    endtask

    task automatic test_shift();
        logic [31:0] exp_v;
        prog_q.delete();
        prog_q.push_back(enc_u(20'h80000, 5'd1));
        prog_q.push_back(enc_i(12'h055, 5'd0, 3'd0, 5'd4, O_I));
        prog_q.push_back(enc_i(12'h404, 5'd1, 3'd5, 5'd4, O_I));   // srai x4,x1,4
        prog_q.push_back(enc_s(12'h050, 5'd4, 5'd0));
        start_prog();
        mem[20] = 32'd0;
        run_prog("srai");
`ifdef TOP_DUV_SHIFT_EN
        exp_v = 32'hF8000000;
`else
        exp_v = 32'h00000055;
`endif
        checks++;
        if (mem[20] !== exp_v) begin
            errors++;
            $display("FAIL srai: mem[0x50]=%h, required %h", mem[20], exp_v);
        end
    endtask

    task automatic gen_random();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  f7;
        int          k;
        prog_q.delete();
        for (int i = 0; i < 40; i++) begin
            k   = $urandom_range(0, 9);
            rd  = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            f3  = 3'($urandom_range(0, 7));
            imm = 12'($urandom);
            case (k)
                0: begin
                    f7 = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
                    if ($urandom_range(0, 9) == 0) f7 = 7'h01;
                    prog_q.push_back(enc_r(f7, rs2, rs1, f3, rd));
                end
                1: begin
                    if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
                    prog_q.push_back(enc_i(imm, rs1, f3, rd, O_I));
                end
                2: prog_q.push_back(enc_u(20'($urandom), rd));
                3: prog_q.push_back(enc_i(12'(12'h200 + 4 * $urandom_range(0, 127)), 5'd0, 3'd2, rd, O_LW));
                4: prog_q.push_back(enc_s(12'(12'h200 + 4 * $urandom_range(0, 127)), rs2, 5'd0));
                5: prog_q.push_back(enc_b(13'(4 * $urandom_range(1, 4)), rs2, rs1, 3'($urandom_range(0, 1))));
                6: prog_q.push_back(enc_j(21'(4 * $urandom_range(1, 4)), rd));
                7: prog_q.push_back({25'($urandom), 7'h7F});
                default: prog_q.push_back(enc_i(imm, rs1, 3'd0, rd, O_I));
            endcase
        end
        for (int i = 0; i < 4; i++) prog_q.push_back(NOP);
        for (int r = 1; r < 8; r++) prog_q.push_back(enc_s(12'(12'h3E0 + 4 * r), 5'(r), 5'd0));
    endtask

    task automatic test_random();
        int bad;
        for (int p = 0; p < 6; p++) begin
            gen_random();
            start_prog();
            run_prog($sformatf("rand%0d", p));
            bad = 0;
            for (int i = 128; i < 256; i++) if (mem[i] !== model_mem[i]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand%0d data_memory: %0d differing words, required 0", p, bad);
            end
        end
    endtask

    initial begin
        RSTa = 1'b0;
        test_reset();
        test_addi_sw();
        test_load_store();
        test_branch();
        test_x0_jal();
        test_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
